mem_read_arbiter: RTL

MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

---
 rtl/mem_read_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mem_read_arbiter.sv
// Two-requester AXI-lite read arbiter (instruction fetch on lane 0, data load
// on lane 1) in front of one shared memory slave. One read is in flight at a
// time; ties are broken round-robin against the previous owner.
module mem_read_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  // requester side
  input  logic [1:0]          arvalid_m,
  output logic [1:0]          arready_m,
  input  logic [2*ADDR_W-1:0] araddr_m,
  input  logic [5:0]          arprot_m,
  output logic [1:0]          rvalid_m,
  input  logic [1:0]          rready_m,
  output logic [2*DATA_W-1:0] rdata_m,
  output logic [1:0]          rresp_m,
  // shared slave side
  output logic                arvalid_s,
  input  logic                arready_s,
  output logic [ADDR_W-1:0]   araddr_s,
  output logic [2:0]          arprot_s,
  input  logic                rvalid_s,
  output logic                rready_s,
  input  logic [DATA_W-1:0]   rdata_s,
  input  logic                rresp_s,
  // status
  output logic [1:0]          grant,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       lastOwner_q, lastOwner_d;
  logic       ownerIdx;

  // grant is one-hot, so its upper bit is the owner index (0 = fetch, 1 = load)
  assign ownerIdx = grant_q[1];

  // State, grant and round-robin history registers; reset lets fetch win the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= 2'b00;
      lastOwner_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      lastOwner_q <= lastOwner_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, wait for address and data handshakes,
  // and only record a new last owner when a read actually completes
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    lastOwner_d = lastOwner_q;
    unique case (state_q)
      IDLE: begin
        if (arvalid_m != 2'b00) begin
          state_d = ADDR;
          if (arvalid_m == 2'b11) begin
            grant_d = lastOwner_q ? 2'b01 : 2'b10;
          end else begin
            grant_d = arvalid_m;
          end
        end
      end
      ADDR: begin
        if (!arvalid_m[ownerIdx]) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end else if (arready_s) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (rvalid_s && rready_m[ownerIdx]) begin
          state_d     = IDLE;
          grant_d     = 2'b00;
          lastOwner_d = ownerIdx;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // Channel steering: only the granted lane sees the slave, and only in the
  // phase that belongs to it; everything else is held at zero
  always_comb begin
    arvalid_s = 1'b0;
    araddr_s  = '0;
    arprot_s  = 3'b000;
    arready_m = 2'b00;
    rvalid_m  = 2'b00;
    rresp_m   = 2'b00;
    rready_s  = 1'b0;
    unique case (state_q)
      ADDR: begin
        arvalid_s           = arvalid_m[ownerIdx];
        araddr_s            = ownerIdx ? araddr_m[2*ADDR_W-1:ADDR_W] : araddr_m[ADDR_W-1:0];
        arprot_s            = ownerIdx ? arprot_m[5:3] : arprot_m[2:0];
        arready_m[ownerIdx] = arready_s;
      end
      DATA: begin
        rvalid_m[ownerIdx] = rvalid_s;
        rresp_m[ownerIdx]  = rresp_s;
        rready_s           = rready_m[ownerIdx];
      end
      default: begin
      end
    endcase
  end

  // Read data fans out to both lanes; rvalid_m alone says whose it is
  assign rdata_m = {rdata_s, rdata_s};
  assign grant   = grant_q;
  assign busy    = (state_q != IDLE);

endmodule
